// File: rtl/mips_sim_pkg.sv
// Shared types and constants for the MIPS run controller: FSM states, exit-reason codes and the
// default magic exit-store address.
package mips_sim_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReset,
    StRun,
    StDone
  } run_state_e;

  localparam logic [1:0] EXIT_NONE    = 2'd0;
  localparam logic [1:0] EXIT_STORE   = 2'd1;
  localparam logic [1:0] EXIT_HALT    = 2'd2;
  localparam logic [1:0] EXIT_TIMEOUT = 2'd3;

  localparam logic [31:0] DEFAULT_EXIT_ADDR = 32'hFFFF_FFFC;

endpackage

// File: rtl/halt_detector.sv
// Flags a CPU self-loop: the PC has matched its previous-cycle value on HALT_REPEAT consecutive
// tracked cycles. clear_i drops history so the first tracked cycle never compares.
module halt_detector #(
  parameter int unsigned HALT_REPEAT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  output logic        halted_o
);

  logic [31:0] prev_q;
  logic [31:0] rep_q;
  logic        valid_q;
  logic        same;

  assign same     = valid_q && (pc_i == prev_q);
  // rep_q counts earlier matches, so the current match completes the run
  assign halted_o = (HALT_REPEAT != 0) && same && (rep_q == HALT_REPEAT - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      prev_q  <= '0;
      rep_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= pc_i;
      valid_q <= 1'b1;
      if (same) begin
        rep_q <= (&rep_q) ? rep_q : rep_q + 32'd1;
      end else begin
        rep_q <= '0;
      end
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Sequences a single-cycle MIPS CPU through reset, a bounded run and a frozen stop, and reports
// whether the run ended on an exit store, a self-loop halt or the cycle budget.
module mips_run_controller
  import mips_sim_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned MAX_CYCLES   = 6,
  parameter int unsigned HALT_REPEAT  = 4,
  parameter logic [31:0] EXIT_ADDR    = DEFAULT_EXIT_ADDR,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          cpu_pc,
  input  logic                 cpu_mem_write,
  input  logic [31:0]          cpu_mem_addr,
  input  logic [31:0]          cpu_mem_wdata,
  output logic                 cpu_reset_n,
  output logic                 cpu_run,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [1:0]           exit_reason,
  output logic [31:0]          exit_code,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned          RcWidth = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RcWidth-1:0]   RcLoad  = RcWidth'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_e           state_q;
  logic [RcWidth-1:0]   rst_cnt_q;
  logic                 cpu_reset_n_q, cpu_run_q, busy_q, done_q, pass_q, timeout_q;
  logic [1:0]           reason_q;
  logic [31:0]          code_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic                 halted;
  logic                 exit_store;
  logic                 budget_out;
  logic [CNT_WIDTH-1:0] count_inc;

  assign exit_store = cpu_mem_write && (cpu_mem_addr == EXIT_ADDR);
  assign budget_out = (MAX_CYCLES != 0) && (count_q == CntLast);
  // Saturation only matters with the budget disabled; otherwise the run ends first
  assign count_inc  = (&count_q) ? count_q : count_q + CNT_WIDTH'(1);

  halt_detector #(
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detector (
    .clk_i    (clock),
    .rst_i    (reset),
    .clear_i  (state_q != StRun),
    .pc_i     (cpu_pc),
    .halted_o (halted)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      cpu_reset_n_q <= 1'b0;
      cpu_run_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      reason_q      <= EXIT_NONE;
      code_q        <= '0;
      count_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StReset;
            rst_cnt_q     <= RcLoad;
            cpu_reset_n_q <= 1'b0;
            cpu_run_q     <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            reason_q      <= EXIT_NONE;
            code_q        <= '0;
            count_q       <= '0;
          end
        end
        StReset: begin
          if (rst_cnt_q == '0) begin
            state_q       <= StRun;
            cpu_reset_n_q <= 1'b1;
            cpu_run_q     <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q - RcWidth'(1);
          end
        end
        StRun: begin
          count_q <= count_inc;
          if (exit_store || halted || budget_out) begin
            state_q   <= StDone;
            cpu_run_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
          if (exit_store) begin
            reason_q <= EXIT_STORE;
            code_q   <= cpu_mem_wdata;
            pass_q   <= (cpu_mem_wdata == 32'd0);
          end else if (halted) begin
            reason_q <= EXIT_HALT;
            pass_q   <= 1'b1;
          end else if (budget_out) begin
            reason_q  <= EXIT_TIMEOUT;
            timeout_q <= 1'b1;
            pass_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cpu_reset_n = cpu_reset_n_q;
  assign cpu_run     = cpu_run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign exit_reason = reason_q;
  assign exit_code   = code_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Randomised scoreboard bench for mips_run_controller: each run's expected result comes from a
// cycle-by-cycle reference model and is checked when done rises.
module tb_mips_run_controller;
  import mips_sim_pkg::*;

  localparam int RC   = 2;
  localparam int MAXC = 24;
  localparam int HR   = 4;
  localparam logic [31:0] EXIT = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cpu_pc = '0;
  logic        cpu_mem_write = 1'b0;
  logic [31:0] cpu_mem_addr = '0;
  logic [31:0] cpu_mem_wdata = '0;
  logic        cpu_reset_n, cpu_run, busy, done, pass, timeout;
  logic [1:0]  exit_reason;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;

  mips_run_controller #(
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MAXC),
    .HALT_REPEAT  (HR),
    .EXIT_ADDR    (EXIT),
    .CNT_WIDTH    (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .cpu_pc        (cpu_pc),
    .cpu_mem_write (cpu_mem_write),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_reset_n   (cpu_reset_n),
    .cpu_run       (cpu_run),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .exit_reason   (exit_reason),
    .exit_code     (exit_code),
    .cycle_count   (cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  reason;
    logic        pass;
    logic        to;
    logic [31:0] code;
    logic [31:0] count;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] pc_a   [0:MAXC];
  logic        we_a   [0:MAXC];
  logic [31:0] addr_a [0:MAXC];
  logic [31:0] data_a [0:MAXC];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: walk RUN cycles in order, first matching rule ends the run.
  function automatic exp_t model();
    exp_t e;
    int   eq;
    e  = '0;
    eq = 0;
    for (int c = 1; c <= MAXC; c++) begin
      e.count = 32'(c);
      if (we_a[c] && addr_a[c] == EXIT) begin
        e.reason = 2'd1;
        e.pass   = (data_a[c] == 32'd0);
        e.code   = data_a[c];
        return e;
      end
      eq = (c >= 2 && pc_a[c] == pc_a[c-1]) ? eq + 1 : 0;
      if (eq >= HR) begin
        e.reason = 2'd2;
        e.pass   = 1'b1;
        return e;
      end
    end
    e.reason = 2'd3;
    e.to     = 1'b1;
    e.count  = 32'(MAXC);
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int c);
    cpu_pc        = pc_a[c];
    cpu_mem_write = we_a[c];
    cpu_mem_addr  = addr_a[c];
    cpu_mem_wdata = data_a[c];
  endtask

  task automatic idle_bus();
    cpu_mem_write = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_wdata = '0;
  endtask

  task automatic fill_inc(input logic [31:0] base);
    for (int c = 0; c <= MAXC; c++) begin
      pc_a[c]   = base + 32'(4 * c);
      we_a[c]   = 1'b0;
      addr_a[c] = '0;
      data_a[c] = '0;
    end
  endtask

  task automatic fill_random();
    int unsigned stall_pct;
    int unsigned s;
    stall_pct = $urandom_range(0, 3) * 33;
    pc_a[0]   = $urandom & 32'h00FF_FFF0;
    we_a[0]   = 1'b0;
    addr_a[0] = '0;
    data_a[0] = '0;
    for (int c = 1; c <= MAXC; c++) begin
      pc_a[c]   = pc_a[c-1] + (($urandom_range(0, 99) < stall_pct) ? 32'd0 : 32'd4);
      we_a[c]   = ($urandom_range(0, 5) == 0);
      addr_a[c] = $urandom & 32'h0FFF_FFFC;
      data_a[c] = $urandom;
    end
    s = $urandom_range(1, MAXC);
    we_a[s]   = 1'b0;
    addr_a[s] = EXIT;
    if ($urandom_range(0, 1) == 1) begin
      s = $urandom_range(1, MAXC);
      we_a[s]   = 1'b1;
      addr_a[s] = EXIT;
      data_a[s] = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
    end
  endtask

  task automatic run_one();
    exp_q.push_back(model());
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("rstn_low_in_reset", 32'(cpu_reset_n), 32'd0);
    chk("count_cleared", cycle_count, 32'd0);
    chk("done_cleared", 32'(done), 32'd0);
    chk("reason_cleared", 32'(exit_reason), 32'd0);
    repeat (RC - 1) begin
      tick();
      chk("rstn_held", 32'(cpu_reset_n), 32'd0);
    end
    for (int c = 1; c <= MAXC; c++) begin
      tick();
      if (c == 1) begin
        chk("rstn_high_in_run", 32'(cpu_reset_n), 32'd1);
        chk("run_in_run", 32'(cpu_run), 32'd1);
      end
      drive(c);
    end
    tick();
    idle_bus();
    chk("done_within_budget", 32'(done), 32'd1);
    chk("run_frozen_in_done", 32'(cpu_run), 32'd0);
    chk("rstn_high_in_done", 32'(cpu_reset_n), 32'd1);
    chk("busy_low_in_done", 32'(busy), 32'd0);
    repeat (2) tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rstn"}, 32'(cpu_reset_n), 32'd0);
    chk({tag, "_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_reason"}, 32'(exit_reason), 32'd0);
    chk({tag, "_code"}, exit_code, 32'd0);
    chk({tag, "_count"}, cycle_count, 32'd0);
  endtask

  // Monitor: pop one expectation per rising edge of done.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending run at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("exit_reason", 32'(exit_reason), 32'(mon_e.reason));
          chk("pass", 32'(pass), 32'(mon_e.pass));
          chk("timeout", 32'(timeout), 32'(mon_e.to));
          chk("exit_code", exit_code, mon_e.code);
          chk("cycle_count", cycle_count, mon_e.count);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Power-on reset, then idle with no start.
    repeat (2) tick();
    reset = 1'b0;
    check_idle("por");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rstn", 32'(cpu_reset_n), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_count", cycle_count, 32'd0);
    end

    // Plain timeout.
    fill_inc(32'h100);
    run_one();

    // Exit store of 0, then of 5, on RUN cycle 10 (restart from DONE).
    fill_inc(32'h200);
    we_a[10] = 1'b1; addr_a[10] = EXIT; data_a[10] = 32'd0;
    run_one();
    data_a[10] = 32'd5;
    run_one();

    // PC frozen at 0x40 from RUN cycle 3.
    fill_inc(32'h34);
    for (int c = 3; c <= MAXC; c++) pc_a[c] = 32'h40;
    run_one();

    // Exit store on the same cycle the halt would fire.
    we_a[7] = 1'b1; addr_a[7] = EXIT; data_a[7] = 32'd9;
    run_one();

    // Decoys: store to a neighbouring address and unstrobed exit address.
    fill_inc(32'h500);
    we_a[3] = 1'b1; addr_a[3] = EXIT - 32'd4; data_a[3] = 32'd0;
    we_a[4] = 1'b0; addr_a[4] = EXIT;
    run_one();

    // reset and start together in DONE: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_idle("rst_start");

    // Mid-run reset during RUN cycle 2.
    fill_inc(32'h800);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RC - 1) tick();
    tick();
    drive(1);
    tick();
    drive(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_bus();
    check_idle("abort");
    tick();
    chk("abort_stays_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 24; r++) begin
      fill_random();
      run_one();
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
